// File: rtl/skinny_ctrl_pkg.sv
// skinny_ctrl_pkg: shared state type, default sizes and round-constant step for the SKINNY serial sequencer
package skinny_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_N, LOAD_S, SB, MC, OUTPUT, DONE} state_e;
  localparam int ROUNDS_DEF = 40;
  localparam int SB_CYC_DEF = 16;
  localparam int MC_CYC_DEF = 4;
  localparam int BEATS = 16;
  localparam logic [5:0] RC_INIT = 6'h00;
  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction
endpackage

// File: rtl/skinny_rc_lfsr.sv
// skinny_rc_lfsr: 6-bit round-constant LFSR with init/step and con byte formatting
module skinny_rc_lfsr
  import skinny_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init_i,
  input  logic       sb_i,
  input  logic [4:0] cyc_i,
  output logic [7:0] con_o
);
  logic [5:0] rc_q, rc_d, rc_nxt;
  logic step;
  assign rc_nxt = rc_step(rc_q);
  assign step = sb_i && cyc_i == 5'd0;
  assign rc_d = init_i ? RC_INIT : step ? rc_nxt : rc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) rc_q <= RC_INIT;
    else rc_q <= rc_d;
  // the c=0 byte carries the freshly stepped constant, so round 0 already sees 6'h01
  assign con_o = !sb_i ? 8'h00 :
                 cyc_i == 5'd0 ? {4'h0, rc_nxt[3:0]} :
                 cyc_i == 5'd4 ? {6'h0, rc_q[5:4]} :
                 cyc_i == 5'd8 ? 8'h02 : 8'h00;
endmodule

// File: rtl/skinny_serial_ctrl.sv
// skinny_serial_ctrl: sequencer for one byte-serial SKINNY-128-384 TBC call (load, 40 rounds, output)
// Define SKINNY_CTRL_DEC_EN to drive sdec from the latched dec on OUTPUT beats; otherwise encrypt-only.
module skinny_serial_ctrl
  import skinny_ctrl_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int SB_CYC = SB_CYC_DEF,
  parameter int MC_CYC = MC_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ld_nonce,
  input  logic       ld_key,
  input  logic       new_msg,
  input  logic       notk1,
  input  logic       dec,
  input  logic [7:0] dom,
  input  logic       pdi_valid,
  output logic       pdi_ready,
  output logic       pdo_valid,
  input  logic       pdo_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] sen,
  output logic       sdec,
  output logic       schain,
  output logic       smxc,
  output logic       smode,
  output logic       srst,
  output logic [7:0] con,
  output logic [7:0] domain,
  output logic       tk1se,
  output logic       tk1ksch,
  output logic       tk1chain,
  output logic       tk1rst,
  output logic       tk1correct_cnt,
  output logic       tk1s,
  output logic       tk1n,
  output logic       tk2ksch,
  output logic       tk2in,
  output logic       tk2chain,
  output logic       tk2correct,
  output logic       tk3ksch,
  output logic       tk3in,
  output logic       tk3chain,
  output logic       tk3correct
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, lim;
  logic [5:0] round_q, round_d;
  logic ld_key_q, notk1_q, dec_q;
  logic [7:0] dom_q;
  logic accept, loading, sb, counting, beat, last;
  assign accept = start && state_q == IDLE;
  assign loading = state_q == LOAD_N || state_q == LOAD_S;
  assign sb = state_q == SB;
  assign counting = state_q != IDLE && state_q != DONE;
  // LOAD beats need pdi_valid, OUTPUT beats need pdo_ready, compute cycles always advance
  assign beat = loading ? pdi_valid : state_q == OUTPUT ? pdo_ready : 1'b1;
  assign lim = sb ? 5'(SB_CYC - 1) : state_q == MC ? 5'(MC_CYC - 1) : 5'(BEATS - 1);
  assign last = beat && cnt_q == lim;
  skinny_rc_lfsr u_rc (
    .clk(clk), .rst(rst), .init_i(accept), .sb_i(sb), .cyc_i(cnt_q), .con_o(con)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      round_q <= round_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_key_q <= 1'b0;
      notk1_q <= 1'b0;
      dec_q <= 1'b0;
      dom_q <= 8'h00;
    end else if (accept) begin
      ld_key_q <= ld_key;
      notk1_q <= notk1;
      dec_q <= dec;
      dom_q <= dom;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = !counting || !beat ? cnt_q : last ? 5'd0 : cnt_q + 5'd1;
    round_d = accept ? 6'd0 : state_q == MC && last ? round_q + 6'd1 : round_q;
    case (state_q)
      IDLE:    if (start) state_d = ld_nonce ? LOAD_N : LOAD_S;
      LOAD_N:  if (last) state_d = LOAD_S;
      LOAD_S:  if (last) state_d = SB;
      SB:      if (last) state_d = MC;
      MC:      if (last) state_d = round_q == 6'(ROUNDS - 1) ? OUTPUT : SB;
      OUTPUT:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sen = 4'h0;
    sdec = 1'b0;
    schain = 1'b0;
    smxc = 1'b0;
    smode = 1'b0;
    srst = 1'b0;
    tk1se = 1'b0;
    tk1ksch = 1'b0;
    tk1chain = 1'b0;
    tk1correct_cnt = 1'b0;
    tk1s = 1'b0;
    tk2ksch = 1'b0;
    tk2in = 1'b0;
    tk2chain = 1'b0;
    tk2correct = 1'b0;
    tk3ksch = 1'b0;
    tk3in = 1'b0;
    tk3chain = 1'b0;
    tk3correct = 1'b0;
    done = 1'b0;
    case (state_q)
      LOAD_N: begin
        tk2in = beat;
        tk2chain = beat;
      end
      LOAD_S: begin
        sen = {4{beat}};
        srst = beat && cnt_q == 5'd0;
        tk3in = beat && ld_key_q;
        tk3chain = beat && ld_key_q;
        tk1se = beat;
      end
      SB: begin
        sen = 4'hF;
        schain = 1'b1;
        tk1chain = 1'b1;
        tk2chain = 1'b1;
        tk3chain = 1'b1;
        tk1s = cnt_q < 5'(SB_CYC / 2);
        tk1ksch = cnt_q == lim;
        tk2ksch = cnt_q == lim;
        tk3ksch = cnt_q == lim;
      end
      MC: begin
        sen = 4'hF;
        smxc = 1'b1;
      end
      OUTPUT: begin
        sen = {4{beat}};
        schain = beat;
        smode = beat;
        tk2correct = beat;
        tk3correct = beat;
`ifdef SKINNY_CTRL_DEC_EN
        sdec = beat && dec_q;
`else
        sdec = dec_q & 1'b0;
`endif
      end
      DONE: begin
        tk1correct_cnt = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end
  assign busy = state_q != IDLE;
  assign pdi_ready = loading;
  assign pdo_valid = state_q == OUTPUT;
  assign tk1n = busy && notk1_q;
  assign tk1rst = accept && new_msg;
  assign domain = dom_q;
endmodule

// File: tb/tb_skinny_serial_ctrl.sv
// tb_skinny_serial_ctrl: randomized call-level check of skinny_serial_ctrl against a phase/beat model
module tb_skinny_serial_ctrl;
  typedef struct packed {
    logic pdi_ready, pdo_valid, busy, done;
    logic [3:0] sen;
    logic sdec, schain, smxc, smode, srst;
    logic [7:0] con, domain;
    logic tk1se, tk1ksch, tk1chain, tk1rst, tk1correct_cnt, tk1s, tk1n;
    logic tk2ksch, tk2in, tk2chain, tk2correct;
    logic tk3ksch, tk3in, tk3chain, tk3correct;
  } ovec_t;
`ifdef SKINNY_CTRL_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ld_nonce = 1'b0, ld_key = 1'b0, new_msg = 1'b0;
  logic notk1 = 1'b0, dec = 1'b0, pdi_valid = 1'b0, pdo_ready = 1'b0;
  logic [7:0] dom = 8'h00;
  logic pdi_ready, pdo_valid, busy, done, sdec, schain, smxc, smode, srst;
  logic [3:0] sen;
  logic [7:0] con, domain;
  logic tk1se, tk1ksch, tk1chain, tk1rst, tk1correct_cnt, tk1s, tk1n;
  logic tk2ksch, tk2in, tk2chain, tk2correct, tk3ksch, tk3in, tk3chain, tk3correct;
  ovec_t act;
  int vectors = 0, miscompares = 0;
  logic [5:0] rcs [0:40];
  logic [7:0] con0 [0:7];
  logic [7:0] rc_lo [0:7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F, 8'h0E, 8'h0D, 8'h0B};
  skinny_serial_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ld_nonce(ld_nonce), .ld_key(ld_key), .new_msg(new_msg),
    .notk1(notk1), .dec(dec), .dom(dom), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
    .pdo_valid(pdo_valid), .pdo_ready(pdo_ready), .busy(busy), .done(done), .sen(sen), .sdec(sdec),
    .schain(schain), .smxc(smxc), .smode(smode), .srst(srst), .con(con), .domain(domain),
    .tk1se(tk1se), .tk1ksch(tk1ksch), .tk1chain(tk1chain), .tk1rst(tk1rst),
    .tk1correct_cnt(tk1correct_cnt), .tk1s(tk1s), .tk1n(tk1n), .tk2ksch(tk2ksch), .tk2in(tk2in),
    .tk2chain(tk2chain), .tk2correct(tk2correct), .tk3ksch(tk3ksch), .tk3in(tk3in),
    .tk3chain(tk3chain), .tk3correct(tk3correct)
  );
  always #5 clk = ~clk;
  assign act = {pdi_ready, pdo_valid, busy, done, sen, sdec, schain, smxc, smode, srst, con, domain,
                tk1se, tk1ksch, tk1chain, tk1rst, tk1correct_cnt, tk1s, tk1n,
                tk2ksch, tk2in, tk2chain, tk2correct, tk3ksch, tk3in, tk3chain, tk3correct};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // mode: 0 always ready, 1 pdi_valid toggles, 2 pdo_ready low 5 cycles at output beat 7, 3 random
  task automatic run_call(input bit nonce, input bit key, input bit nm, input bit nk1, input bit dc,
                          input logic [7:0] dm, input int mode, input int rst_at,
                          output int dut_k, output int mdl_k);
    int ld_total, li, t, oi, stl, r, w;
    bit aborted;
    ovec_t e;
    ld_total = nonce ? 32 : 16;
    li = 0; t = 0; oi = 0; stl = 0;
    dut_k = -1; mdl_k = -1; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; ld_nonce = nonce; ld_key = key; new_msg = nm; notk1 = nk1; dec = dc; dom = dm;
    #1 check("tk1rst_at_start", tk1rst, nm);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000 && mdl_k < 0; k++) begin
      pdi_valid = mode == 1 ? !k[0] : mode == 3 ? $urandom_range(0, 3) != 0 : 1'b1;
      pdo_ready = mode == 2 ? !(oi == 7 && stl < 5) : mode == 3 ? $urandom_range(0, 2) != 0 : 1'b1;
      start = mode == 3 && li >= ld_total && t < 800 && $urandom_range(0, 49) == 0;
      ld_nonce = $urandom_range(0, 1);
      dom = 8'($urandom);
      #1;
      if (rst_at >= 0 && li >= ld_total && t == rst_at) begin
        rst = 1'b1;
        #1 check("rst_mid_call", act, '0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      e = '0;
      e.busy = 1'b1;
      e.tk1n = nk1;
      e.domain = dm;
      if (li < ld_total) begin
        e.pdi_ready = 1'b1;
        if (pdi_valid && nonce && li < 16) begin
          e.tk2in = 1'b1;
          e.tk2chain = 1'b1;
        end else if (pdi_valid) begin
          e.sen = 4'hF;
          e.srst = li == ld_total - 16;
          e.tk3in = key;
          e.tk3chain = key;
          e.tk1se = 1'b1;
        end
      end else if (t < 800) begin
        r = t / 20;
        w = t % 20;
        e.sen = 4'hF;
        if (w < 16) begin
          e.schain = 1'b1;
          e.tk1chain = 1'b1;
          e.tk2chain = 1'b1;
          e.tk3chain = 1'b1;
          e.tk1s = w < 8;
          {e.tk1ksch, e.tk2ksch, e.tk3ksch} = {3{w == 15}};
          e.con = w == 0 ? {4'h0, rcs[r + 1][3:0]} : w == 4 ? {6'h0, rcs[r + 1][5:4]} : w == 8 ? 8'h02 : 8'h00;
        end else e.smxc = 1'b1;
        if (w == 0 && r < 8) con0[r] = con;
      end else if (oi < 16) begin
        e.pdo_valid = 1'b1;
        if (pdo_ready) begin
          e.sen = 4'hF;
          e.schain = 1'b1;
          e.smode = 1'b1;
          e.tk2correct = 1'b1;
          e.tk3correct = 1'b1;
          e.sdec = DEC_EN && dc;
        end
      end else begin
        e.done = 1'b1;
        e.tk1correct_cnt = 1'b1;
        mdl_k = k;
      end
      check($sformatf("cycle%0d", k), act, e);
      if (done && dut_k < 0) dut_k = k;
      if (li < ld_total) li += int'(pdi_valid);
      else if (t < 800) t++;
      else if (oi < 16) begin
        if (pdo_ready) oi++;
        else stl++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    e = '0;
    e.domain = aborted ? 8'h00 : dm;
    check("idle_after_call", act, e);
  endtask
  initial begin
    int dk, mk;
    rcs[0] = 6'h00;
    for (int i = 1; i <= 40; i++) rcs[i] = {rcs[i - 1][4:0], ~(rcs[i - 1][5] ^ rcs[i - 1][4])};
    repeat (3) @(negedge clk);
    #1 check("reset_state", act, '0);
    rst = 1'b0;
    run_call(1, 1, 1, 0, 0, 8'hA5, 0, -1, dk, mk);
    check("t1_latency", dk, 848);
    for (int i = 0; i < 8; i++) check($sformatf("t2_con_round%0d", i), con0[i], rc_lo[i]);
    run_call(0, 1, 0, 1, 0, 8'h5A, 1, -1, dk, mk);
    check("t3_latency", dk, 847);
    run_call(0, 0, 1, 0, 0, 8'h11, 2, -1, dk, mk);
    check("t4_latency", dk, 837);
    run_call(1, 1, 0, 1, 0, 8'h77, 0, 400, dk, mk);
    run_call(1, 0, 1, 0, 0, 8'h42, 0, -1, dk, mk);
    check("t5_restart_latency", dk, 848);
    run_call(0, 1, 0, 1, 1, 8'h3C, 0, -1, dk, mk);
    check("t6_latency", dk, 832);
    for (int n = 0; n < 4; n++) begin
      run_call($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), 8'($urandom), 3, -1, dk, mk);
      check($sformatf("rand%0d_latency", n), dk, mk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
